// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-word bit positions and the fetch FSM states.
package cpu_pkg;

  localparam logic [5:0] OP_BRZ = 6'h00;
  localparam logic [5:0] OP_BRN = 6'h01;
  localparam logic [5:0] OP_BRC = 6'h02;
  localparam logic [5:0] OP_BRO = 6'h03;
  localparam logic [5:0] OP_LDA = 6'h04;
  localparam logic [5:0] OP_STA = 6'h05;
  localparam logic [5:0] OP_BRA = 6'h06;
  localparam logic [5:0] OP_JMP = 6'h07;
  localparam logic [5:0] OP_RET = 6'h08;
  localparam logic [5:0] OP_ADD = 6'h09;
  localparam logic [5:0] OP_SUB = 6'h0A;
  localparam logic [5:0] OP_AND = 6'h0B;
  localparam logic [5:0] OP_OR  = 6'h0C;
  localparam logic [5:0] OP_XOR = 6'h0D;
  localparam logic [5:0] OP_NOT = 6'h0E;
  localparam logic [5:0] OP_SHL = 6'h0F;
  localparam logic [5:0] OP_SHR = 6'h10;
  localparam logic [5:0] OP_LDI = 6'h11;
  localparam logic [5:0] OP_LDM = 6'h12;
  localparam logic [5:0] OP_STM = 6'h13;
  localparam logic [5:0] OP_PSH = 6'h14;
  localparam logic [5:0] OP_POP = 6'h15;
  localparam logic [5:0] OP_NOP = 6'h16;
  localparam logic [5:0] OP_CMP = 6'h17;
  localparam logic [5:0] OP_ROL = 6'h18;
  localparam logic [5:0] OP_INC = 6'h19;
  localparam logic [5:0] OP_DEC = 6'h1A;

  localparam int CTRL_NEXT  = 7;
  localparam int CTRL_BR    = 6;
  localparam int CTRL_ALUOP = 5;
  localparam int CTRL_LSE   = 4;
  localparam int CTRL_LDM   = 3;
  localparam int CTRL_LACC  = 2;
  localparam int CTRL_ABS   = 1;
  localparam int CTRL_SPO   = 0;

  localparam logic [7:0] CTRL_ILLEGAL = 8'hFF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses; push on full and pop on empty are ignored here and
// reported to the caller through full/empty.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W = AW + 1;

  logic [SP_W-1:0] sp_q, sp_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_idx, rd_idx;

  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign dout   = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer. Define RET_STACK_EN to build the return
// stack for jmp/ret; without it jmp acts as bra and ret halts as illegal.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [5:0]         opcode,
  output logic [9:0]         operand,
  input  logic [7:0]         ctrl,
  input  logic               flag_z,
  input  logic               flag_n,
  input  logic               flag_c,
  input  logic               flag_o,
  output logic [ADDR_W-1:0]  pc,
  output logic               instr_valid,
  output logic               halted,
  output logic               stack_err
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q, req_d;
  logic               stack_err_q, stack_err_d;
  logic [ADDR_W-1:0]  pc_inc, target;
  logic               commit;

`ifdef RET_STACK_EN
  logic              push, pop, stack_full, stack_empty;
  logic [ADDR_W-1:0] stack_dout;

  ret_stack #(
    .DEPTH(STACK_DEPTH),
    .W    (ADDR_W)
  ) u_ret_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .dout (stack_dout),
    .full (stack_full),
    .empty(stack_empty)
  );
`endif

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign target      = ir_q[ADDR_W-1:0];
  assign opcode      = ir_q[15:10];
  assign operand     = ir_q[9:0];
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign pc          = pc_q;
  assign halted      = (state_q == HALT);
  assign stack_err   = stack_err_q;
  assign instr_valid = commit;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    stack_err_d = stack_err_q;
    commit      = 1'b0;
`ifdef RET_STACK_EN
    push        = 1'b0;
    pop         = 1'b0;
`endif
    unique case (state_q)
      FETCH: begin
        if (req_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (ctrl == CTRL_ILLEGAL) begin
          state_d = HALT;
        end else if (ctrl[CTRL_NEXT]) begin
          commit  = 1'b1;
          pc_d    = pc_inc;
          state_d = FETCH;
          case (opcode)
            OP_BRZ: if (flag_z) pc_d = target;
            OP_BRN: if (flag_n) pc_d = target;
            OP_BRC: if (flag_c) pc_d = target;
            OP_BRO: if (flag_o) pc_d = target;
            OP_BRA: pc_d = target;
`ifdef RET_STACK_EN
            OP_JMP: begin
              if (stack_full) begin
                commit      = 1'b0;
                pc_d        = pc_q;
                state_d     = HALT;
                stack_err_d = 1'b1;
              end else begin
                push = 1'b1;
                pc_d = target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                commit      = 1'b0;
                pc_d        = pc_q;
                state_d     = HALT;
                stack_err_d = 1'b1;
              end else begin
                pop  = 1'b1;
                pc_d = stack_dout;
              end
            end
`else
            OP_JMP: pc_d = target;
            OP_RET: begin
              commit  = 1'b0;
              pc_d    = pc_q;
              state_d = HALT;
            end
`endif
            default: ;
          endcase
        end
      end
      HALT: ;
      default: state_d = HALT;
    endcase
    // Registered so the request only rises on the first edge after reset.
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      req_q       <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      req_q       <= req_d;
      stack_err_q <= stack_err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; follows RET_STACK_EN like the RTL.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [5:0]  opcode;
  logic [9:0]  operand;
  logic [7:0]  ctrl;
  logic        flag_z, flag_n, flag_c, flag_o;
  logic [9:0]  pc;
  logic        instr_valid;
  logic        halted;
  logic        stack_err;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .ADDR_W(10),
    .INSTR_W(16),
    .STACK_DEPTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .opcode     (opcode),
    .operand    (operand),
    .ctrl       (ctrl),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_c     (flag_c),
    .flag_o     (flag_o),
    .pc         (pc),
    .instr_valid(instr_valid),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: ack the word, pass DECODE, and return inside EXEC.
  task automatic applyStimulus(input logic [15:0] instr, input logic [7:0] c, input logic [3:0] flags);
    imem_ack  = 1'b1;
    imem_data = instr;
    ctrl      = c;
    {flag_z, flag_n, flag_c, flag_o} = flags;
    step();
    imem_ack = 1'b0;
    step();
  endtask

  task automatic execInstr(input string tag, input logic [15:0] instr, input logic [3:0] flags,
                           input logic [9:0] exp_pc);
    applyStimulus(instr, 8'h80, flags);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    step();
    checkOutput({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    checkOutput({tag, "_req"}, 32'(imem_req), 32'd1);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [9:0] opnd);
    return {op, opnd};
  endfunction

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_data = 16'h0000;
    ctrl = 8'h00;
    {flag_z, flag_n, flag_c, flag_o} = 4'b0000;
    #3;
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_stack_err", 32'(stack_err), 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_operand", 32'(operand), 32'd0);

    // ADD with two wait states before the ack
    ctrl = 8'h80;
    releaseReset();
    checkOutput("wait_req1", 32'(imem_req), 32'd1);
    checkOutput("wait_addr", 32'(imem_addr), 32'd0);
    step();
    checkOutput("wait_req2", 32'(imem_req), 32'd1);
    step();
    checkOutput("wait_req3", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    imem_data = mk(6'h09, 10'h155);
    step();
    imem_ack = 1'b0;
    checkOutput("dec_req", 32'(imem_req), 32'd0);
    checkOutput("dec_valid", 32'(instr_valid), 32'd0);
    checkOutput("dec_opcode", 32'(opcode), 32'h09);
    checkOutput("dec_operand", 32'(operand), 32'h155);
    step();
    checkOutput("exec_valid", 32'(instr_valid), 32'd1);
    checkOutput("exec_pc", 32'(pc), 32'd0);
    step();
    checkOutput("add_pc", 32'(pc), 32'd1);
    checkOutput("add_valid_low", 32'(instr_valid), 32'd0);
    checkOutput("add_addr", 32'(imem_addr), 32'd1);

    execInstr("brz_taken", mk(6'h00, 10'h040), 4'b1000, 10'h040);
    execInstr("brz_not", mk(6'h00, 10'h080), 4'b0111, 10'h041);
    execInstr("brn_taken", mk(6'h01, 10'h123), 4'b0100, 10'h123);
    execInstr("brc_not", mk(6'h02, 10'h200), 4'b1001, 10'h124);
    execInstr("bro_taken", mk(6'h03, 10'h300), 4'b0001, 10'h300);
    execInstr("bra_top", mk(6'h06, 10'h3FF), 4'b0000, 10'h3FF);
    execInstr("add_wrap", mk(6'h09, 10'h000), 4'b0000, 10'h000);

    // Stall in EXEC, with a stray ack that must be ignored
    applyStimulus(mk(6'h09, 10'h0AA), 8'h00, 4'b0000);
    checkOutput("stall_valid1", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1;
    imem_data = mk(6'h06, 10'h3FF);
    step();
    imem_ack = 1'b0;
    checkOutput("stall_valid2", 32'(instr_valid), 32'd0);
    checkOutput("stall_req", 32'(imem_req), 32'd0);
    checkOutput("stall_pc", 32'(pc), 32'd0);
    checkOutput("stray_ack_opcode", 32'(opcode), 32'h09);
    ctrl = 8'h80;
    #1;
    checkOutput("stall_release_valid", 32'(instr_valid), 32'd1);
    step();
    checkOutput("stall_release_pc", 32'(pc), 32'd1);

    execInstr("bra_010", mk(6'h06, 10'h010), 4'b0000, 10'h010);
    execInstr("jmp_100", mk(6'h07, 10'h100), 4'b0000, 10'h100);
`ifdef RET_STACK_EN
    execInstr("ret_011", mk(6'h08, 10'h000), 4'b0000, 10'h011);
    for (int i = 0; i < 8; i++) begin
      execInstr("jmp_fill", mk(6'h07, 10'h200), 4'b0000, 10'h200);
    end
    applyStimulus(mk(6'h07, 10'h200), 8'h80, 4'b0000);
    checkOutput("ovf_valid", 32'(instr_valid), 32'd0);
    step();
    checkOutput("ovf_halted", 32'(halted), 32'd1);
    checkOutput("ovf_stack_err", 32'(stack_err), 32'd1);
    checkOutput("ovf_pc", 32'(pc), 32'h200);
    checkOutput("ovf_req", 32'(imem_req), 32'd0);
`else
    applyStimulus(mk(6'h08, 10'h000), 8'h80, 4'b0000);
    checkOutput("ret_illegal_valid", 32'(instr_valid), 32'd0);
    step();
    checkOutput("ret_illegal_halted", 32'(halted), 32'd1);
    checkOutput("ret_illegal_stack_err", 32'(stack_err), 32'd0);
    checkOutput("ret_illegal_pc", 32'(pc), 32'h100);
    checkOutput("ret_illegal_req", 32'(imem_req), 32'd0);
`endif

    rst = 1'b1;
    #1;
    checkOutput("rst1_pc", 32'(pc), 32'd0);
    checkOutput("rst1_halted", 32'(halted), 32'd0);
    checkOutput("rst1_stack_err", 32'(stack_err), 32'd0);
    releaseReset();

    // Illegal opcode halts with pc frozen
    execInstr("pre_illegal", mk(6'h09, 10'h000), 4'b0000, 10'h001);
    applyStimulus(mk(6'h3F, 10'h3FF), 8'hFF, 4'b1111);
    checkOutput("illegal_valid", 32'(instr_valid), 32'd0);
    step();
    checkOutput("illegal_halted", 32'(halted), 32'd1);
    checkOutput("illegal_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    checkOutput("halt_pc_frozen", 32'(pc), 32'd1);
    checkOutput("halt_still", 32'(halted), 32'd1);
    checkOutput("halt_req_low", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst2_pc", 32'(pc), 32'd0);
    checkOutput("rst2_halted", 32'(halted), 32'd0);
    ctrl = 8'h80;
    releaseReset();

    // Asynchronous reset with a request outstanding
    execInstr("pre_async", mk(6'h09, 10'h000), 4'b0000, 10'h001);
    checkOutput("async_req_before", 32'(imem_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_req", 32'(imem_req), 32'd0);
    checkOutput("async_pc", 32'(pc), 32'd0);
    releaseReset();
    checkOutput("after_async_req", 32'(imem_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter sequencer sitting directly upstream of the control unit. Fetches instructions from instruction memory over a req/ack handshake, presents the opcode to the control unit, and consumes the returned 8-bit control word and ALU flags to compute the next PC. Handles branches, absolute jumps, subroutine call/return, and illegal-opcode halt.

## Interface
Parameters:
- ADDR_W, 10: PC and instruction-memory address width. Must be ≤ 10.
- INSTR_W, 16: instruction width. Opcode is instr[15:10]; operand is instr[9:0].
- STACK_DEPTH, 8: return-stack entries. Power of two.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  ADDR_W  fetch address
- imem_req  out  1  fetch request
- imem_ack  in  1  memory returns imem_data this cycle
- imem_data  in  INSTR_W  instruction word
- opcode  out  6  to control unit
- operand  out  10  instruction operand, to datapath
- ctrl  in  8  control word: [7] next, [6] br, [5] aluOp, [4] lse, [3] ldm, [2] lacc, [1] abs, [0] spo
- flag_z, flag_n, flag_c, flag_o  in  1 each  ALU flags
- pc  out  ADDR_W  current PC
- instr_valid  out  1  one-cycle pulse: instruction executing
- halted  out  1  core stopped
- stack_err  out  1  return-stack overflow/underflow

## Operation
- States: FETCH, DECODE, EXEC, HALT.
- FETCH: drive imem_req=1, imem_addr=pc. On imem_ack: latch imem_data into IR, go to DECODE. imem_req held until ack.
- DECODE: opcode/operand driven from IR; one cycle for the combinational CU to settle; go to EXEC.
- EXEC: sample ctrl and flags.
  - ctrl==8'hFF (illegal): go to HALT; pc unchanged.
  - ctrl[7]==0: stall in EXEC, no pulse, no PC change.
  - Otherwise pulse instr_valid and update pc, then go to FETCH.
- Next-PC rules (target = operand[ADDR_W-1:0]):
  - brz/brn/brc/bro (opcode 0–3): target if flag_z/n/c/o respectively, else pc+1.
  - bra (6): target.
  - jmp (7): push pc+1, then target.
  - ret (8): pop into pc.
  - All others: pc+1.
- pc+1 wraps modulo 2^ADDR_W.
- Return stack: push on full or pop on empty → HALT, stack_err=1, pc and sp unchanged.
- HALT: imem_req=0, halted=1. Exit only via rst.

## Timing
- Reset values: pc=0, IR=0 (opcode=0, operand=0), imem_req=0, instr_valid=0, halted=0, stack_err=0, sp=0, state=FETCH.
- imem_req asserts on the first clock edge after rst deasserts.
- Latency: minimum 3 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC). Each cycle without ack adds one cycle.
- pc updates on the edge leaving EXEC. The next FETCH uses the new pc.
- instr_valid is high exactly during the EXEC cycle that commits.
- rst mid-operation: all outputs go to their reset values immediately (asynchronous); an outstanding request is abandoned.
- imem_ack outside FETCH is ignored.

## Configuration
- RET_STACK_EN defined: return stack present; jmp pushes and ret pops as above.
- RET_STACK_EN undefined:
  - No stack storage.
  - jmp behaves as bra (no push).
  - ret halts as an illegal instruction.
  - stack_err is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (BRZ..DEC, 6'h00–6'h1A)
  - ctrl bit indices (CTRL_NEXT=7 … CTRL_SPO=0)
  - CTRL_ILLEGAL=8'hFF
  - fetch state enum
- Sub-module ret_stack (LIFO: push, pop, din, dout, full, empty), instantiated only under RET_STACK_EN.

## Test plan
- Reset, then imem_data=ADD with ack after 2 wait cycles → imem_req high 3 cycles, instr_valid pulse 2 cycles later, pc 0→1.
- BRZ operand=0x040: with flag_z=1 → pc=0x040; with flag_z=0 → pc=pc+1.
- pc=0x3FF, ADD → pc wraps to 0x000.
- JMP 0x100 at pc=0x010, then RET → pc=0x100, then pc=0x011. Push STACK_DEPTH+1 JMPs → halted=1, stack_err=1.
- Opcode 6'h3F (ctrl=8'hFF) → HALT, imem_req=0, pc frozen. rst pulse → pc=0, halted=0.
- Assert rst during FETCH with imem_req=1 → imem_req=0 immediately, without waiting for a clock edge.
